// File: rtl/data_cache_wb.sv
`default_nettype none
// ============================================================================
// Module  : data_cache_wb
// Brief   : Direct-mapped, write-back, write-allocate blocking data cache with
//           line-wide memory handshake and saturating hit/miss counters.
// Revision: 1.0 - initial release
// ============================================================================
module data_cache_wb #(
  parameter int NUM_LINES  = 4,
  parameter int LINE_WORDS = 4,
  parameter int CNT_W      = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic                    req_write,
  input  logic [31:0]             req_addr,
  input  logic [3:0]              req_be,
  input  logic [31:0]             req_wdata,
  output logic [31:0]             rsp_rdata,
  output logic                    stall,
  output logic                    mem_req_valid,
  output logic                    mem_req_write,
  output logic [31:0]             mem_req_addr,
  output logic [32*LINE_WORDS-1:0] mem_req_wdata,
  input  logic                    mem_req_ready,
  input  logic                    mem_rsp_valid,
  input  logic [32*LINE_WORDS-1:0] mem_rsp_rdata,
  output logic [CNT_W-1:0]        hit_cnt,
  output logic [CNT_W-1:0]        miss_cnt
);

  localparam int c_wordBits    = $clog2(LINE_WORDS);
  localparam int c_indexBits   = $clog2(NUM_LINES);
  localparam int c_tagBits     = 30 - c_wordBits - c_indexBits;
  localparam int c_tagLsb      = 2 + c_wordBits + c_indexBits;
  localparam int c_wordSelBits = (c_wordBits > 0) ? c_wordBits : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WB_REQ  = 2'd1,
    S_RD_REQ  = 2'd2,
    S_RD_WAIT = 2'd3
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [c_tagBits-1:0] r_tag  [NUM_LINES];
  logic [31:0]          r_data [NUM_LINES][LINE_WORDS];
  logic                 r_replay;
  logic [CNT_W-1:0]     r_hitCnt;
  logic [CNT_W-1:0]     r_missCnt;

  logic [c_indexBits-1:0]   w_index;
  logic [c_tagBits-1:0]     w_tag;
  logic [c_wordSelBits-1:0] w_word;
  logic                     w_lineHit;
  logic                     w_hit;
  logic                     w_miss;
  logic                     w_storeHit;
  logic                     w_refill;
  logic                     w_unused;

  assign w_index  = req_addr[2+c_wordBits +: c_indexBits];
  assign w_tag    = req_addr[c_tagLsb +: c_tagBits];
  assign w_unused = ^req_addr[1:0];

  generate
    if (c_wordBits > 0) begin : g_wordSel
      assign w_word = req_addr[2 +: c_wordBits];
    end else begin : g_singleWord
      assign w_word = 1'b0;
    end
  endgenerate

  assign w_lineHit  = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_hit      = (r_state == S_IDLE) && req_valid && w_lineHit;
  assign w_miss     = (r_state == S_IDLE) && req_valid && !w_lineHit;
  assign w_storeHit = w_hit && req_write;
  assign w_refill   = (r_state == S_RD_WAIT) && mem_rsp_valid;

  assign rsp_rdata = w_hit ? r_data[w_index][w_word] : 32'd0;
  assign hit_cnt   = r_hitCnt;
  assign miss_cnt  = r_missCnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // The request is held stable while stalled, so the index/tag of the
  // pending access also address the victim and the refill target.
  always_comb begin
    w_nextState   = r_state;
    stall         = 1'b1;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = 32'd0;
    for (int i = 0; i < LINE_WORDS; i++) begin
      mem_req_wdata[32*i +: 32] = r_data[w_index][i];
    end
    case (r_state)
      S_IDLE: begin
        stall = w_miss;
        if (w_miss) begin
          w_nextState = (r_valid[w_index] && r_dirty[w_index]) ? S_WB_REQ : S_RD_REQ;
        end
      end
      S_WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {r_tag[w_index], w_index, {(c_wordBits+2){1'b0}}};
        if (mem_req_ready) begin
          w_nextState = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {w_tag, w_index, {(c_wordBits+2){1'b0}}};
        if (mem_req_ready) begin
          w_nextState = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (mem_rsp_valid) begin
          w_nextState = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Replay cycle after a refill hits but was already counted as a miss.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid   <= '0;
      r_dirty   <= '0;
      r_replay  <= 1'b0;
      r_hitCnt  <= '0;
      r_missCnt <= '0;
    end else begin
      r_replay <= w_refill;
      if (w_refill) begin
        r_valid[w_index] <= 1'b1;
        r_dirty[w_index] <= 1'b0;
      end else if (w_storeHit && (req_be != 4'd0)) begin
        r_dirty[w_index] <= 1'b1;
      end
      if (w_hit && !r_replay && (r_hitCnt != '1)) begin
        r_hitCnt <= r_hitCnt + 1'b1;
      end
      if (w_miss && (r_missCnt != '1)) begin
        r_missCnt <= r_missCnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_refill) begin
      r_tag[w_index] <= w_tag;
      for (int i = 0; i < LINE_WORDS; i++) begin
        r_data[w_index][i] <= mem_rsp_rdata[32*i +: 32];
      end
    end else if (w_storeHit) begin
      for (int b = 0; b < 4; b++) begin
        if (req_be[b]) begin
          r_data[w_index][w_word][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire
